// File: rtl/valid_ready_src_pkg.sv
// valid_ready_src_pkg
// Shared definitions for the valid/ready stream source:
//   vr_src_state_t : transmitter FSM states
//   VR_LFSR_TAPS   : Galois feedback mask (x^8+x^6+x^5+x^4+1)
//   VR_LFSR_DFLT   : reset value and replacement for an all-zero seed
//   vr_lfsr_next() : one right-shift step of the Galois LFSR
package valid_ready_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } vr_src_state_t;

    localparam logic [7:0] VR_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] VR_LFSR_DFLT = 8'h01;

    function automatic logic [7:0] vr_lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ VR_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/valid_ready_src_if.sv
// valid_ready_src_if
// Valid/ready stream bundle.
//   vld  : word valid (source -> sink)
//   data : word payload, N bits (source -> sink)
//   rdy  : sink ready (sink -> source)
// Modports: master = stream source, slave = stream sink.
interface valid_ready_src_if #(
    parameter int N = 4
);
    logic         vld;
    logic [N-1:0] data;
    logic         rdy;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/valid_ready_src_lfsr.sv
// vr_lfsr8
// 8-bit Galois LFSR used to pick idle gaps between words.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low; q returns to VR_LFSR_DFLT
//   load : load seed (an all-zero seed is replaced by VR_LFSR_DFLT)
//   seed : value to load
//   step : advance one step (load has priority)
//   q    : current state
module vr_lfsr8
    import valid_ready_src_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= VR_LFSR_DFLT;
        end else if (load) begin
            // an all-zero state would lock the LFSR up forever
            q <= (seed == 8'h00) ? VR_LFSR_DFLT : seed;
        end else if (step) begin
            q <= vr_lfsr_next(q);
        end
    end

endmodule

// File: rtl/valid_ready_src.sv
// valid_ready_src
// Valid/ready burst transmitter. A start pulse in IDLE launches burst_len
// words counting up from start_val (mod 2^N); optional LFSR-driven one-cycle
// idle gaps between words. All outputs are registered.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-low
//   start     : launch request, only honoured in IDLE
//   start_val : first word of the burst
//   burst_len : words in the burst (0 = empty burst, done only)
//   gap_en    : enable random gap insertion for this burst
//   seed      : LFSR seed for this burst
//   busy      : burst in progress
//   done      : one-cycle pulse after the last handshake / empty burst
//   dwn       : stream output (master modport)
module valid_ready_src
    import valid_ready_src_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             start_val,
    input  logic [LEN_W-1:0]         burst_len,
    input  logic                     gap_en,
    input  logic [7:0]               seed,
    output logic                     busy,
    output logic                     done,
    valid_ready_src_if.master        dwn
);

    vr_src_state_t    state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     data_q, data_d;
    logic             gap_en_q, gap_en_d;
    logic             vld_q, busy_q, done_q;
    logic             done_d;
    logic             lfsr_load, lfsr_step;
    logic [7:0]       lfsr_q, lfsr_nx;
    logic             hs;

    vr_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign lfsr_nx = vr_lfsr_next(lfsr_q);
    assign hs      = vld_q & dwn.rdy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        gap_en_d  = gap_en_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d   = SEND;
                        cnt_d     = burst_len;
                        data_d    = start_val;
                        gap_en_d  = gap_en;
                        lfsr_load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (hs) begin
                    cnt_d     = cnt_q - 1'b1;
                    lfsr_step = 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = data_q + 1'b1;
                        // gap decision uses the post-step LFSR value
                        state_d = (gap_en_q && lfsr_nx[0]) ? GAP : SEND;
                    end
                end
            end
            GAP: begin
                state_d = SEND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // vld/busy are registered from the next state so no output decodes
    // combinationally from the state register or from dwn.rdy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            gap_en_q <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            gap_en_q <= gap_en_d;
            vld_q    <= (state_d == SEND);
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
        end
    end

    assign dwn.vld  = vld_q;
    assign dwn.data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_valid_ready_src.sv
module tb_valid_ready_src;

    localparam int N     = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic [N-1:0]     start_val;
    logic [LEN_W-1:0] burst_len;
    logic             gap_en;
    logic [7:0]       seed;
    logic             busy;
    logic             done;

    logic rdy_fix  = 1'b0;
    logic rdy_rand = 1'b0;
    logic rnd_bit  = 1'b0;

    valid_ready_src_if #(.N(N)) dwn_if ();
    assign dwn_if.rdy = rdy_rand ? rnd_bit : rdy_fix;

    valid_ready_src #(.N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_val (start_val),
        .burst_len (burst_len),
        .gap_en    (gap_en),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .dwn       (dwn_if)
    );

    int checks = 0;
    int passes = 0;

    // scoreboard: expected words in order, and expected length of each burst
    logic [N-1:0] exp_q[$];
    int           len_q[$];
    int           words_seen = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // reference LFSR step written arithmetically: halve, fold taps on odd
    function automatic int model_step(input int s);
        return (s / 2) ^ (((s % 2) == 1) ? 184 : 0);
    endfunction

    // busy cycles of a burst when the sink is always ready
    function automatic int model_busy(input int len, input bit ge, input int sd);
        int s;
        int cyc;
        s   = (sd == 0) ? 1 : sd;
        cyc = 0;
        for (int i = 0; i < len; i++) begin
            cyc++;
            s = model_step(s);
            if (i < len - 1 && ge && (s % 2) == 1) cyc++;
        end
        return cyc;
    endfunction

    task automatic drive_start(input int sv, input int len, input bit ge, input int sd);
        start     = 1'b1;
        start_val = N'(sv);
        burst_len = LEN_W'(len);
        gap_en    = ge;
        seed      = 8'(sd);
        for (int i = 0; i < len; i++) exp_q.push_back(N'(sv + i));
        len_q.push_back(len);
    endtask

    task automatic issue(input int sv, input int len, input bit ge, input int sd);
        @(posedge clk); #1;
        drive_start(sv, len, ge, sd);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cyc);
        bit found;
        found    = 1'b0;
        busy_cyc = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
            else if (busy) busy_cyc++;
        end
        check("done_timeout", int'(found), 1);
    endtask

    // random ready source
    initial begin
        forever begin
            @(posedge clk); #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // monitor: compares handshakes and done pulses against the scoreboard
    logic         prev_vld  = 1'b0;
    logic         prev_rdy  = 1'b0;
    logic [N-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("hold_vld", int'(dwn_if.vld), 1);
                check("hold_data", int'(dwn_if.data), int'(prev_data));
            end
            if (dwn_if.vld && dwn_if.rdy) begin
                check("word_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("data", int'(dwn_if.data), int'(exp_q.pop_front()));
                words_seen++;
            end
            if (done) begin
                check("done_expected", int'(len_q.size() > 0), 1);
                check("done_busy", int'(busy), 0);
                if (len_q.size() > 0) check("burst_words", words_seen, len_q.pop_front());
                words_seen = 0;
            end
            prev_vld  = dwn_if.vld;
            prev_rdy  = dwn_if.rdy;
            prev_data = dwn_if.data;
        end
    end

    initial begin
        int bc;
        int len, sv, sd;
        bit ge;

        rst = 1'b0; start = 1'b0; start_val = '0; burst_len = '0; gap_en = 1'b0; seed = '0;
        #2;
        check("rst_vld", int'(dwn_if.vld), 0);
        check("rst_data", int'(dwn_if.data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // basic burst
        rdy_fix = 1'b1;
        issue(3, 5, 1'b0, 1);
        wait_done(bc);
        check("basic_busy", bc, 5);

        // wrap-around
        issue(14, 4, 1'b0, 1);
        wait_done(bc);
        check("wrap_busy", bc, model_busy(4, 1'b0, 1));

        // back-pressure on word 0
        rdy_fix = 1'b0;
        issue(9, 3, 1'b0, 1);
        repeat (4) @(negedge clk);
        check("bp_vld", int'(dwn_if.vld), 1);
        check("bp_data", int'(dwn_if.data), 9);
        @(posedge clk); #1 rdy_fix = 1'b1;
        wait_done(bc);

        // gap pattern
        issue(0, 4, 1'b1, 8'h01);
        wait_done(bc);
        check("gap_seed01", bc, model_busy(4, 1'b1, 1));
        issue(0, 4, 1'b1, 8'h02);
        wait_done(bc);
        check("gap_seed02", bc, model_busy(4, 1'b1, 2));
        issue(5, 6, 1'b1, 8'h00);
        wait_done(bc);
        check("gap_seed00", bc, model_busy(6, 1'b1, 0));

        // empty burst, then restart in the done cycle
        @(posedge clk); #1;
        drive_start(5, 0, 1'b0, 1);
        @(posedge clk); #1;
        check("empty_done", int'(done), 1);
        check("empty_busy", int'(busy), 0);
        check("empty_vld", int'(dwn_if.vld), 0);
        drive_start(10, 3, 1'b0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_vld", int'(dwn_if.vld), 1);
        check("restart_data", int'(dwn_if.data), 10);
        wait_done(bc);

        // reset mid-burst after 2 of 6 words
        issue(2, 6, 1'b0, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_vld", int'(dwn_if.vld), 0);
        check("mid_rst_data", int'(dwn_if.data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_words", words_seen, 2);
        exp_q.delete();
        len_q.delete();
        words_seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_done", int'(done), 0);
        issue(7, 3, 1'b0, 1);
        wait_done(bc);
        check("post_rst_busy", bc, 3);

        // randomized bursts
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(0, 12);
            sv  = $urandom_range(0, 15);
            sd  = $urandom_range(0, 255);
            ge  = 1'($urandom_range(0, 1));
            rdy_rand = 1'($urandom_range(0, 1));
            rdy_fix  = 1'b1;
            issue(sv, len, ge, sd);
            wait_done(bc);
            if (!rdy_rand) check("rand_busy", bc, model_busy(len, ge, sd));
        end
        rdy_rand = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_words_left", exp_q.size(), 0);
        check("sb_bursts_left", len_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/valid_ready_src.md
# valid_ready_src

Valid/ready stream transmitter that drives the `dwn_*` (input) side of the `valid_ready` slice. On a `start` pulse it emits a burst of `burst_len` words: the first word is `start_val`, and each later word increments by one. It fully obeys the valid/ready rules under back-pressure. An optional 8-bit LFSR inserts idle gaps between words, so the block serves as both a bench traffic source and a reusable on-chip stream generator.

## Interface
- `N`, default 4: data width; must match the downstream slice's `N`.
- `LEN_W`, default 8: width of the burst-length field.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous reset, active-low; deassertion is synchronous to `clk`.
- `start` in 1: one-cycle launch request. Sampled only in IDLE.
- `start_val` in N: first data word; latched when `start` is accepted.
- `burst_len` in LEN_W: number of words to send, latched on `start`. 0 means an empty burst.
- `gap_en` in 1: enables LFSR gap insertion; latched on `start`.
- `seed` in 8: LFSR seed, latched on `start`. A value of 0 is replaced by 8'h01.
- `busy` out 1: high while a burst is in progress.
- `done` out 1: one-cycle pulse after the final handshake, or after an empty burst.
- `dwn_vld` out 1: transmit valid.
- `dwn_data` out N: transmit data.
- `dwn_rdy` in 1: downstream ready.

## Operation
- **States:** IDLE, SEND, GAP.
- **IDLE**
  - Outputs: `dwn_vld`=0, `busy`=0.
  - `start` with `burst_len`≠0: latch the inputs; `cnt`=`burst_len`; `dwn_data`=`start_val`; go to SEND.
  - `start` with `burst_len`=0: stay in IDLE and pulse `done` the next cycle.
- **SEND**
  - Outputs: `dwn_vld`=1, `busy`=1.
  - A handshake is `dwn_vld`&`dwn_rdy`. On each handshake, decrement `cnt` and advance the LFSR one step.
  - Handshake with `cnt`=1: go to IDLE, pulse `done`, drive `dwn_vld`=0.
  - Other handshake: `dwn_data`+1, wrapping modulo 2^N (e.g. F→0 at N=4). Then go to GAP if `gap_en` is latched and the new LFSR bit0 is 1; otherwise stay in SEND.
  - No handshake: `dwn_vld` and `dwn_data` hold exactly; the valid is never withdrawn.
- **GAP**
  - Outputs: `dwn_vld`=0, `busy`=1.
  - Lasts exactly one cycle, then returns to SEND. The LFSR does not advance here.
  - `dwn_rdy` is ignored in this state.
- **`start` handling:** `start` is ignored in SEND and GAP. A `start` in the same cycle as the `done` pulse is accepted, because the state is already IDLE.
- **`dwn_rdy` dependence:** `dwn_rdy` may be high before `dwn_vld`. `dwn_vld` never depends combinationally on `dwn_rdy`.
- **LFSR:** 8-bit Galois, taps 8'hB8 (x^8+x^6+x^5+x^4+1), shifting right. Step rule: if bit0=1 then `next = (s>>1)^8'hB8`, else `next = s>>1`.
- **Word count:** exactly `burst_len` handshakes per burst.
- **Reset:** any reset, including one mid-burst, forces IDLE with every output 0 (`dwn_vld`, `dwn_data`, `busy`, `done`), `cnt`=0 and LFSR=8'h01. The interrupted burst is abandoned and `done` is not pulsed.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `start` accepted at edge t → `dwn_vld`=1 and `busy`=1 from t+1.
- Handshake at edge t with more words to send → next word valid at t+1 (no gap), or at t+2 (one GAP cycle).
- Throughput is 1 word/cycle when `gap_en`=0 and `dwn_rdy`=1.
- Final handshake at edge t → `done`=1 and `busy`=0 during cycle t+1.
- Empty burst: `start` at t → `done` at t+1, with `busy` staying 0.

## Structure
- Shared package (`package.svh`):
  - `vr_src_state_t` enum {IDLE, SEND, GAP}.
  - `VR_LFSR_TAPS` = 8'hB8 and `VR_LFSR_DFLT` = 8'h01.
  - The existing `` `T `` clock-period macro.
- Sub-module `vr_lfsr8`: ports `clk`, `rst`, `load`, `seed[7:0]`, `step`, `q[7:0]`. It performs the zero-seed substitution internally.
- Top level: FSM, `cnt`, data register, `done` pulse register.
- Verification: the bench pairs `valid_ready_src` → `valid_ready` (V=0) → an `up_rdy`-driven sink.

## Test plan
- **Basic burst:** `start_val`=4'h3, `burst_len`=5, `gap_en`=0, `dwn_rdy`=1 → data 3,4,5,6,7 on 5 consecutive cycles; `done` one cycle after word 7; `busy` high for exactly 5 cycles.
- **Wrap-around:** `start_val`=4'hE, `burst_len`=4 → E,F,0,1.
- **Back-pressure:** `burst_len`=3, `dwn_rdy` low for 4 cycles while word 0 is valid → `dwn_vld` and `dwn_data` stable throughout, then 3 handshakes total, no duplicates, no drops.
- **Gap pattern:** `seed`=8'h01, `gap_en`=1, `burst_len`=4, `dwn_rdy`=1 → the LFSR sequence after each handshake is 8'hB8, 8'h5C, 8'h2E. Bit0 is 0 each time, so there are no gaps. With `seed`=8'h02 the first step gives 8'h01, so exactly one GAP cycle follows word 0.
- **Empty burst and restart:** `burst_len`=0 → `done` at t+1 with `dwn_vld` never high. Then `start` asserted during a `done` cycle → the new burst begins the next cycle.
- **Reset mid-burst:** assert `rst`=0 after 2 of 6 words → all outputs 0 asynchronously, no `done` pulse. After release, a new `start` begins again at the new `start_val`.
